// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between EX pipeline control and the multiply/divide unit.
// The master drives the request, the slave (muldiv_unit) returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply or restoring divide on magnitudes,
// with signs applied in a final fix-up cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_is_div;
  logic              r_neg_q;   // quotient / product must be negated
  logic              r_neg_r;   // remainder must be negated
  logic              r_div0;
  logic [XLEN-1:0]   r_b;       // |rt|: multiplicand addend or divisor
  logic [XLEN-1:0]   r_rs;      // raw rs, returned in HI on divide-by-zero
  logic [2*XLEN-1:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_accept;
  logic              w_signed;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [XLEN-1:0]   w_rs_abs;
  logic [XLEN-1:0]   w_rt_abs;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [XLEN-1:0]   w_rem_new;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  // Operand magnitudes and sign decode for the issuing instruction
  always_comb begin
    w_accept = bus.start && !bus.flush && (r_state == StIdle);
    w_signed = ~bus.op[0];
    w_rs_neg = w_signed & bus.rs_data[XLEN-1];
    w_rt_neg = w_signed & bus.rt_data[XLEN-1];
    w_rs_abs = w_rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    w_rt_abs = w_rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  end

  // One radix-2 step of shift-add multiply and of restoring divide
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    // Only used when w_ge, so the true difference is below r_b and fits XLEN bits
    w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
    w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
    w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};
  end

  // Sign fix-up of the finished magnitude result
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
  end

  // Control FSM with registered busy/done/HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_b      <= '0;
      r_rs     <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_accept) begin
              if (!bus.op[2]) begin
                r_state  <= StCalc;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_div0   <= bus.op[1] && (bus.rt_data == '0);
                r_b      <= w_rt_abs;
                r_rs     <= bus.rs_data;
                r_acc    <= {{XLEN{1'b0}}, w_rs_abs};
              end else if (bus.op == 3'b100) begin
                r_hi <= bus.rs_data;
              end else if (bus.op == 3'b101) begin
                r_lo <= bus.rs_data;
              end
            end
          end
          StCalc: begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN - 1)) begin
              r_state <= StFix;
            end
          end
          StFix: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (!r_is_div) begin
              r_hi <= w_prod[2*XLEN-1:XLEN];
              r_lo <= w_prod[XLEN-1:0];
            end else if (r_div0) begin
              r_hi <= r_rs;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative MIPS32 multiply/divide unit with the architectural HI/LO registers.
- Sits in EX, directly downstream of the register file read ports: consumes read_data1 (rs) and read_data2 (rt).
- Executes MULT, MULTU, DIV, DIVU as multi-cycle operations, and MTHI/MTLO as single-cycle writes.
- Exposes busy/done so the pipeline control can stall MFHI/MFLO and further mul/div issue.

Parameters:
XLEN  32  operand/HI/LO width; RTL correct for any even XLEN >= 8; iteration counter width = $clog2(XLEN)

Ports:
clk    input   1     clock, all state on rising edge
rst_n  input   1     asynchronous active-low reset
start  input   1     issue request; accepted only when busy=0 and flush=0
op     input   3     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
rs_data  input  XLEN  operand A / dividend / MTHI-MTLO source (from register file port 1)
rt_data  input  XLEN  operand B / divisor (from register file port 2)
flush  input   1     abort in-flight operation (exception/branch squash)
busy   output  1     operation in flight; new start ignored
done   output  1     one-cycle pulse: HI/LO just updated by a mul/div
hi     output  XLEN  HI register
lo     output  XLEN  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand registers 0. Takes effect immediately, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE: on an edge with start=1, flush=0:
  - op 00x/01x: latch |rs|, |rt| (raw values for unsigned ops) and the result signs; counter=0; go to CALC; busy=1 from this edge.
  - op 100: hi<=rs_data. op 101: lo<=rs_data. Stay IDLE, busy stays 0, no done.
  - op 11x: no effect.
- Operands are sampled only at the accepting edge; rs_data/rt_data may change afterwards.
- CALC: one radix-2 step per edge, 32 (XLEN) edges; counter increments; after step XLEN-1, go to FIX.
  - Multiply: shift-add over a 2*XLEN accumulator.
  - Divide: restoring division, XLEN-bit quotient and remainder.
- FIX (one edge): apply signs, write hi/lo, done=1 for exactly the following cycle, busy=0, return to IDLE.
- Latency: start accepted at edge N -> hi/lo valid and done=1 after edge N+XLEN+1 (33 for XLEN=32). busy=1 after edges N..N+XLEN.
- Back-to-back: start may be accepted in the cycle done=1 (busy=0).
- Multiply: {hi,lo} = full 2*XLEN product. MULT is signed (product negated iff operand signs differ); MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - DIV truncates toward zero: quotient negative iff signs differ; remainder takes the sign of the dividend.
  - Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (two's-complement wrap).
- Divide by zero (DIV or DIVU): lo=all ones, hi=rs_data as sampled. Full latency is still taken and done still pulses.
- start while busy=1: ignored, no queueing, in-flight operation unaffected.
- flush=1 in any state: next edge state=IDLE, busy=0, done=0, hi/lo unchanged (a FIX edge coinciding with flush does not write).
- flush and start in the same cycle: flush wins, start ignored (MTHI/MTLO also suppressed).
- hi/lo change only at a FIX edge, on MTHI/MTLO, or at reset.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, done still at 33 cycles.
5. DIVU issued, then start(MTHI) at cycle 5 -> ignored; flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. Then MTHI 0x1234 -> hi=0x1234 after one edge, busy stays 0.
6. rst_n deasserted-low mid-MULT (cycle 20) -> busy=0, done=0, hi=lo=0 immediately. After release, MULTU 3*4 -> lo=12, hi=0.
